// File: rtl/mem_bus_master.sv
// Avalon-MM load/store master: big-endian core view over a little-endian byte-laned bus.
// Optional `MISALIGN_TRAP_EN` turns misaligned requests into error responses instead of aligning them down.
module mem_bus_master #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                busy,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    input  logic                waitrequest,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   readdata
);
    localparam int NB  = DATA_W / 8;
    localparam int LB  = $clog2(NB);
    localparam int WCW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t            r_state;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [LB-1:0]     r_off;
    logic [WCW-1:0]    r_wait_cnt;
    logic              r_read;
    logic              r_bus_write;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_writedata;
    logic [NB-1:0]     r_byteenable;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    int                w_s;
    int                w_off_raw;
    int                w_off;
    logic              w_illegal;
    logic              w_reject;
    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wdata;
    int                w_ld_s;
    int                w_ld_off;
    logic              w_ld_sign;
    logic [DATA_W-1:0] w_ld;
    logic              w_timeout;

    // Request decode: lane offset after alignment, lane enables and big-endian store steering.
    always_comb begin
        w_s       = 1 << req_size;
        w_off_raw = int'(req_addr[LB-1:0]);
        w_off     = w_off_raw & ~(w_s - 1);
        w_illegal = (w_s > NB);
        w_be      = '0;
        w_wdata   = '0;
        for (int k = 0; k < NB; k++) begin
            if (!w_illegal && k >= w_off && k < w_off + w_s) begin
                w_be[k]           = 1'b1;
                w_wdata[8*k +: 8] = req_wdata[8*(w_s - 1 - (k - w_off)) +: 8];
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign w_reject = w_illegal || (w_off != w_off_raw);
`else
    assign w_reject = w_illegal;
`endif

    // Load assembly: result byte gi comes from the lane holding address (base + off + S-1-gi).
    assign w_ld_s    = 1 << r_size;
    assign w_ld_off  = int'(r_off);
    assign w_ld_sign = readdata[8*w_ld_off + 7];

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_load
            assign w_ld[8*gi +: 8] = (gi < w_ld_s) ? readdata[8*(w_ld_off + w_ld_s - 1 - gi) +: 8]
                                                   : {8{r_signed & w_ld_sign}};
        end
    endgenerate

    assign w_timeout = (WAIT_TIMEOUT > 0) && (r_wait_cnt == WCW'(WAIT_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_off        <= '0;
            r_wait_cnt   <= '0;
            r_read       <= 1'b0;
            r_bus_write  <= 1'b0;
            r_address    <= '0;
            r_writedata  <= '0;
            r_byteenable <= '0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_signed   <= req_signed;
                        r_off      <= LB'(w_off);
                        r_wait_cnt <= '0;
                        if (w_reject) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_err        <= 1'b1;
                            r_rdata      <= '0;
                        end else begin
                            r_state      <= S_BUS;
                            r_read       <= ~req_write;
                            r_bus_write  <= req_write;
                            r_address    <= {req_addr[ADDR_W-1:LB], {LB{1'b0}}};
                            r_byteenable <= w_be;
                            r_writedata  <= w_wdata;
                        end
                    end
                end
                S_BUS: begin
                    if (!waitrequest || w_timeout) begin
                        r_state      <= S_RESP;
                        r_read       <= 1'b0;
                        r_bus_write  <= 1'b0;
                        r_byteenable <= '0;
                        r_resp_valid <= 1'b1;
                        r_err        <= waitrequest;
                        r_rdata      <= (r_write || waitrequest) ? '0 : w_ld;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE) && !reset;
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_bus_write;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;
endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master (32-bit bus, 4-cycle wait timeout) against a
// byte-addressed reference model of the big-endian core view.
module tb_mem_bus_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_master #(.DATA_W(32), .ADDR_W(32), .WAIT_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .address(address), .read(read),
        .write(write), .waitrequest(waitrequest), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request: model the expected bus cycle and response, drive it, and compare.
    task automatic txn(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                       input logic [31:0] wd, input int nwait, input logic [31:0] rd);
        int          s, off, lat, cyc, guard;
        logic [31:0] ea, base, exp_be, exp_wd, exp_rd;
        logic        exp_err, on_bus;

        s       = 1 << sz;
        exp_err = 1'b0;
        on_bus  = 1'b1;
        if (s > 4) begin
            exp_err = 1'b1;
            on_bus  = 1'b0;
        end
`ifdef MISALIGN_TRAP_EN
        else if (addr % s != 0) begin
            exp_err = 1'b1;
            on_bus  = 1'b0;
        end
`endif
        ea     = addr - (addr % s);
        off    = int'(ea % 4);
        base   = ea - (ea % 4);
        exp_be = 0;
        exp_wd = 0;
        exp_rd = 0;
        if (on_bus) begin
            // Byte at address ea+j is bus lane off+j; it is value byte j counted from the MSB.
            for (int j = 0; j < s; j++) begin
                exp_be = exp_be | (32'd1 << (off + j));
                if (wr) exp_wd = exp_wd | (((wd >> (8*(s-1-j))) & 32'hFF) << (8*(off+j)));
                else    exp_rd = exp_rd | (((rd >> (8*(off+j))) & 32'hFF) << (8*(s-1-j)));
            end
            if (!wr && sg && s < 4 && exp_rd[8*s-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*s));
        end
        if (!on_bus) lat = 0;
        else if (nwait >= 4) begin
            lat     = 4;
            exp_err = 1'b1;
        end else lat = nwait + 1;

        guard = 0;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", req_ready, 1);
        check("idle_byteenable", byteenable, 0);
        req_valid   = 1'b1;
        req_write   = wr;
        req_size    = sz;
        req_signed  = sg;
        req_addr    = addr;
        req_wdata   = wd;
        readdata    = rd;
        waitrequest = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        req_addr  = $urandom;

        cyc = 0;
        while (resp_valid !== 1'b1 && cyc < 12) begin
            if (cyc < lat) begin
                check("bus_read", read, !wr);
                check("bus_write", write, wr);
                check("bus_address", address, base);
                check("bus_byteenable", byteenable, exp_be);
                if (wr) check("bus_writedata", writedata, exp_wd);
                check("bus_req_ready", req_ready, 0);
            end
            waitrequest = (cyc < nwait);
            @(negedge clk);
            cyc++;
        end
        waitrequest = 1'b0;
        check("resp_latency", cyc, lat);
        check("resp_valid", resp_valid, 1);
        check("resp_err", resp_err, exp_err);
        if (!exp_err || !on_bus) check("resp_rdata", resp_rdata, wr ? 32'd0 : exp_rd);
        check("resp_bus_idle", {read, write}, 2'b00);
        @(negedge clk);
        check("resp_one_cycle", resp_valid, 0);
        $display("txn wr=%0d size=%0d signed=%0d addr=%h wait=%0d -> err=%0d rdata=%h lat=%0d",
                 wr, sz, sg, addr, nwait, exp_err, exp_rd, lat);
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = 2'd0;
        req_signed  = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        waitrequest = 1'b0;
        readdata    = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_outputs", {read, write, address, writedata, byteenable, resp_valid, resp_err},
              '0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'h4433_2211);
        txn(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 0, 32'h0000_8000);
        txn(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 0, 32'h0000_8000);
        txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_ABCD, 0, 32'h1234_5678);
        txn(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 3, 32'h8001_0000);
        txn(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 1, 32'h0000_00F1);
        txn(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 6, 32'hDEAD_BEEF);
        txn(1'b1, 2'd2, 1'b0, 32'h108, 32'hCAFE_F00D, 5, 32'h0);
        txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 32'h4433_2211);
        txn(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, 32'h1111_1111);
        txn(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_005A, 2, 32'h0);

        // Reset while a load is stalled: abandoned with no response.
        while (req_ready !== 1'b1) @(negedge clk);
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_size    = 2'd2;
        req_addr    = 32'h200;
        waitrequest = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_read_high", read, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_read", read, 0);
        check("mid_rst_resp", resp_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        reset       = 1'b0;
        waitrequest = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_resp", resp_valid, 0);
        $display("txn reset mid-bus load addr=00000200 -> abandoned");

        for (int i = 0; i < 150; i++) begin
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, int'($urandom_range(0, 5)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Parametrised Avalon-MM load/store master that sits between the multicycle core and the memory bus.
- Replaces the fixed 32-bit, word-only, no-stall bus hookup with the following:
  - waitrequest-aware stalling.
  - Sub-word (byte/half) byte-lane steering.
  - Big-endian core view over a little-endian byte-laned bus.
  - Sign/zero extension of load data.
  - Optional wait timeout.
- The core issues one request, holds its FSM on `busy`, and consumes a one-cycle response.

Parameters:
- DATA_W, 32: bus/core data width. Must be a power of 2, ≥16, multiple of 8. NB = DATA_W/8 lanes.
- ADDR_W, 32: byte address width.
- WAIT_TIMEOUT, 0: maximum consecutive waitrequest cycles before abort. 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  core request strobe
- req_ready  out  1  block can accept a request (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  log2 of access bytes: 0 = byte, 1 = half, 2 = word, 3 = dword
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store value, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data (0 for stores)
- resp_err  out  1  completion was an error (illegal size, timeout, or misaligned when trapping)
- busy  out  1  state != IDLE
- address  out  ADDR_W  Avalon word-aligned address (low log2(NB) bits = 0)
- read  out  1  Avalon read
- write  out  1  Avalon write
- waitrequest  in  1  Avalon stall
- writedata  out  DATA_W  Avalon write data
- byteenable  out  NB  Avalon lane enables
- readdata  in  DATA_W  Avalon read data

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-high; it is sampled on the rising edge of clk.
  - On reset, the FSM goes to IDLE and these outputs clear to 0: read, write, address, writedata, byteenable, resp_valid, resp_rdata, resp_err.
  - req_ready is 0 while reset is high.
  - A reset mid-BUS abandons the transaction with no response. read/write are low from the next cycle.
- FSM states: IDLE, BUS, RESP.
  - IDLE:
    - req_ready = 1.
    - If req_valid, capture all req_* fields.
    - Illegal request (size bytes > NB), or misaligned request under the trap feature: go to RESP with resp_err = 1 and no bus cycle.
    - Otherwise go to BUS.
  - BUS:
    - Registered read or write = 1. address, byteenable and writedata are held stable for the whole state.
    - When waitrequest = 0 at a clock edge, the transfer completes: latch readdata and go to RESP.
    - If WAIT_TIMEOUT > 0 and waitrequest has been high for WAIT_TIMEOUT consecutive cycles: deassert read/write and go to RESP with resp_err = 1.
    - The wait counter clears on entry to BUS.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. Outside RESP, resp_valid = 0.
- Latency and throughput:
  - Minimum latency is 2 cycles: accept at edge N, BUS from N+1, resp_valid from N+2.
  - Each waitrequest cycle adds 1. Peak throughput is one access per 3 cycles.
- Lane mapping:
  - off = req_addr mod NB. Lane k = bits [8k+7:8k] and holds byte address (base+k).
  - The core value is big-endian: its most-significant byte goes to the lowest address.
  - Store: byteenable = ((1<<S)-1) << off, with S = 1<<req_size.
    - Value byte j (j = 0 is the MSB of the S-byte value) goes to lane off+j.
    - Unused lanes are driven 0.
  - Load: assemble lanes off..off+S-1 MSB-first into an S-byte value, then sign- or zero-extend to DATA_W.
- In IDLE, read = write = 0 and byteenable = 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a request with req_addr mod S != 0 completes with resp_err = 1 and resp_rdata = 0, with no bus cycle. Latency is 1 cycle after accept.
- Undefined: the low log2(S) address bits are cleared and the access proceeds normally with no error.

Test Plan:
- LW addr 0x100, readdata 0x44332211, waitrequest 0 -> byteenable 4'b1111, read high 1 cycle, resp_rdata 0x11223344, resp_valid at accept+2.
- LB signed addr 0x101, readdata 0x00008000 -> byteenable 4'b0010, resp_rdata 0xFFFFFF80. Same request with req_signed = 0 -> 0x00000080.
- SH addr 0x102, wdata 0x0000ABCD -> write high, byteenable 4'b1100, writedata 0xCDAB0000, address 0x100, resp_rdata 0.
- LH addr 0x102, readdata held with waitrequest high 3 cycles -> read and address stable throughout, resp_valid exactly 1 cycle after waitrequest falls, req_ready 0 until the response.
- WAIT_TIMEOUT = 4, waitrequest stuck high -> read drops after 4 cycles, resp_err = 1.
- Reset asserted mid-BUS -> read low next cycle, no resp_valid, req_ready 1 once reset is released.
- With MISALIGN_TRAP_EN: LW addr 0x102 -> no read, resp_err = 1.
- Without MISALIGN_TRAP_EN: LW addr 0x102 -> address 0x100, normal load.
